// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, computed LSB-first as
// a + ~b + 1 through one full-adder cell over WIDTH clock cycles.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_a_sr;
  logic [WIDTH-1:0]  r_b_sr;
  logic [WIDTH-1:0]  r_r_sr;
  logic              r_carry;
  logic [CntW-1:0]   r_cnt;
  logic              r_a_msb;
  logic              r_b_msb;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow;
  logic              r_ovf;

  logic              w_nb;
  logic              w_s;
  logic              w_carry_nxt;
  logic [WIDTH-1:0]  w_r_nxt;
  logic              w_last;

  // Full-adder cell on the current LSBs with the subtrahend bit inverted.
  always_comb begin
    w_nb        = ~r_b_sr[0];
    w_s         = r_a_sr[0] ^ w_nb ^ r_carry;
    w_carry_nxt = (r_a_sr[0] & w_nb) | (r_carry & (r_a_sr[0] ^ w_nb));
    w_r_nxt     = {w_s, r_r_sr[WIDTH-1:1]};
    w_last      = (r_cnt == CntW'(WIDTH - 1));
  end

  // Control FSM plus datapath shift registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            // Carry-in of 1 supplies the +1 of the two's-complement negation.
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_carry <= w_carry_nxt;
          r_r_sr  <= w_r_nxt;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          if (w_last) begin
            r_diff   <= w_r_nxt;
            // No carry out of a + ~b + 1 means the unsigned subtraction borrowed.
            r_borrow <= ~w_carry_nxt;
            r_ovf    <= (r_a_msb != r_b_msb) && (w_s != r_a_msb);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          // start is deliberately ignored here; it is not queued.
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule
